// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register transport record, mux-select enum, defaults.
package wb_pkg;

    localparam int RegWidth            = 32;
    localparam int RegAddrWidth        = 5;
    localparam int WB_LD_DEPTH_DEFAULT = 2;

    // Same layout as the register file's write-port record.
    typedef struct packed {
        logic [RegAddrWidth-1:0] addr;
        logic [RegWidth-1:0]     value;
    } reg_transport_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_ALU,
        WB_SRC_FIFO,
        WB_SRC_LD
    } wb_src_e;

    function automatic logic writes_reg(input reg_transport_t rd);
        return rd.addr != '0;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Strict-order buffer for load results that lost writeback arbitration; exposes its live entries.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_LD_DEPTH_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  reg_transport_t                 push_data,
    input  logic                           pop,
    output reg_transport_t                 head,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH):0]         count,
    output logic [DEPTH-1:0]               valid,
    output reg_transport_t [DEPTH-1:0]     entries
);

    localparam int IW = $clog2(DEPTH);

    logic [IW:0]    wr_ptr_reg;
    logic [IW:0]    rd_ptr_reg;
    reg_transport_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Storage needs no reset: the valid mask below gates every consumer.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg[IW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr_reg[IW-1:0]];
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[IW] != rd_ptr_reg[IW]) &&
                   (wr_ptr_reg[IW-1:0] == rd_ptr_reg[IW-1:0]);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [IW-1:0] offset;
            // Slot is live when its distance past the read pointer is below the fill count.
            assign offset      = IW'(gi) - rd_ptr_reg[IW-1:0];
            assign valid[gi]   = ({1'b0, offset} < count);
            assign entries[gi] = mem[gi];
        end
    endgenerate

endmodule

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results onto the single register-file write port.
// Optional same-cycle bypass outputs (oFwd/oFwdValid) are built when WB_FWD_EN is defined.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int LD_DEPTH   = WB_LD_DEPTH_DEFAULT,
    parameter int REG_WIDTH  = RegWidth,
    parameter int ADDR_WIDTH = RegAddrWidth
) (
    input  logic                       iClk,
    input  logic                       nRst,
    input  logic                       iAluValid,
    input  reg_transport_t             iAluRd,
    output logic                       oAluStall,
    input  logic                       iLdValid,
    input  reg_transport_t             iLdRd,
    output logic                       oLdReady,
    output logic                       oWriteEn,
    output reg_transport_t             oRd,
    output logic [2**ADDR_WIDTH-1:0]   oLdPend
`ifdef WB_FWD_EN
    ,
    output reg_transport_t             oFwd,
    output logic                       oFwdValid
`endif
);

    localparam int CW = $clog2(LD_DEPTH) + 1;

    wb_src_e                          src;
    logic                             fifo_push;
    logic                             fifo_pop;
    reg_transport_t                   fifo_head;
    logic                             fifo_full;
    logic                             fifo_empty;
    logic [CW-1:0]                    fifo_count;
    logic [LD_DEPTH-1:0]              fifo_valid;
    reg_transport_t [LD_DEPTH-1:0]    fifo_entries;
    logic [ADDR_WIDTH-1:0]            sel_addr;
    logic [REG_WIDTH-1:0]             sel_value;
    reg_transport_t                   sel_rd;

    wb_load_fifo #(.DEPTH(LD_DEPTH)) u_fifo (
        .clk       (iClk),
        .rst_n     (nRst),
        .push      (fifo_push),
        .push_data (iLdRd),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .valid     (fifo_valid),
        .entries   (fifo_entries)
    );

    // Ready depends only on the fill count so upstream never sees a path from iAluValid.
    assign oLdReady  = (fifo_count != CW'(LD_DEPTH));
    assign oAluStall = fifo_full & iAluValid;

    always_comb begin
        src       = WB_SRC_NONE;
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (fifo_full) begin
            src      = WB_SRC_FIFO;
            fifo_pop = 1'b1;
        end else if (iAluValid) begin
            src       = WB_SRC_ALU;
            fifo_push = iLdValid;
        end else if (!fifo_empty) begin
            src       = WB_SRC_FIFO;
            fifo_pop  = 1'b1;
            fifo_push = iLdValid;
        end else if (iLdValid) begin
            src = WB_SRC_LD;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_value = '0;
        case (src)
            WB_SRC_ALU:  begin sel_addr = iAluRd.addr;    sel_value = iAluRd.value;    end
            WB_SRC_FIFO: begin sel_addr = fifo_head.addr; sel_value = fifo_head.value; end
            WB_SRC_LD:   begin sel_addr = iLdRd.addr;     sel_value = iLdRd.value;     end
            default:     ;
        endcase
        sel_rd = '{addr: sel_addr, value: sel_value};
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oWriteEn <= 1'b0;
            oRd      <= '0;
        end else begin
            oWriteEn <= (src != WB_SRC_NONE) && writes_reg(sel_rd);
            if (src != WB_SRC_NONE) oRd <= sel_rd;
        end
    end

    // x0 never counts as pending since it is never written.
    always_comb begin
        oLdPend = '0;
        for (int e = 0; e < LD_DEPTH; e++) begin
            if (fifo_valid[e]) oLdPend[fifo_entries[e].addr] = 1'b1;
        end
        oLdPend[0] = 1'b0;
    end

`ifdef WB_FWD_EN
    assign oFwd      = sel_rd;
    assign oFwdValid = (src != WB_SRC_NONE) && writes_reg(sel_rd);
`endif

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Merges the two producers of register results, the in-order ALU pipe and the variable-latency load unit, onto the single register-file write port (`iWriteEn`/`iRd`). It sits directly upstream of `RegisterFile`. Load results that lose arbitration are held in a small FIFO. The block also exports a pending-load register mask so that decode can interlock on WAW and RAW hazards against buffered loads.

## Interface
- `LD_DEPTH`, 2: load FIFO entries; must be a power of two and ≥ 2.
- `REG_WIDTH`, `rv32_isa::RegWidth`: result width.
- `ADDR_WIDTH`, `rv32_isa::RegAddrWidth`: register address width.

Ports:
- `iClk` in 1: the single clock.
- `nRst` in 1: asynchronous, active-low reset.
- `iAluValid` in 1: an ALU result is presented this cycle.
- `iAluRd` in `reg_transport_t`: ALU destination `addr`/`value`.
- `oAluStall` out 1: the ALU must hold `iAluRd` this cycle.
- `iLdValid` in 1: a load result is offered.
- `iLdRd` in `reg_transport_t`: load destination `addr`/`value`.
- `oLdReady` out 1: the load result is accepted when `iLdValid & oLdReady`.
- `oWriteEn` out 1: write strobe to `RegisterFile.iWriteEn`.
- `oRd` out `reg_transport_t`: write data to `RegisterFile.iRd`.
- `oLdPend` out `2**ADDR_WIDTH`: bit r is set while any buffered load targets xr.

## Operation
Priority per cycle; the first matching rule wins:
1. FIFO full: pop the head to the output. `oAluStall = iAluValid`. `oLdReady = 0`.
2. `iAluValid`: ALU result to the output. An accepted load is pushed.
3. FIFO non-empty: pop the head to the output. An accepted load is pushed, so push and pop occur in the same cycle.
4. `iLdValid` with FIFO empty: the load goes straight to the output and is not buffered.
5. Otherwise: `oWriteEn <= 0`. `oRd` holds its last value.

Rules that apply to every cycle:
- `oLdReady = (count != LD_DEPTH)`. It is driven from the count register only, with no combinational path from `iAluValid`.
- `oAluStall = full & iAluValid`. It is combinational.
- A result with `addr == 0` is consumed (popped or accepted) normally, but `oWriteEn <= 0` for it.
- `oLdPend` is the OR over valid FIFO entries of the one-hot of `addr`. Bit 0 is always 0. The entry currently in the output register is not included.
- Decode guarantees that an ALU result never targets a register whose `oLdPend` bit is set. The bench asserts this as a property.
- FIFO order is strict FIFO. Pointers are `$clog2(LD_DEPTH)+1` bits wide and wrap modulo `2*LD_DEPTH`. The full/empty test uses the MSB and compares the remaining bits.

## Timing
- All outputs except `oAluStall` and `oLdReady` are registered. A result accepted at edge N appears on `oWriteEn`/`oRd` after edge N. `RegisterFile` commits it at edge N+1.
- Direct load path (rule 4): latency is 1 cycle, the same as the ALU path.
- A buffered load waits at least 2 cycles.
- Maximum ALU stall per full condition is 1 cycle. A pop frees a slot, so `oLdReady` returns to 1 the next cycle.
- Reset (`nRst` low, asynchronous):
  - `oWriteEn = 0`, `oRd = '0`, `oLdPend = '0`.
  - FIFO is emptied and count is 0.
  - `oLdReady = 1`, `oAluStall = 0`.
- Reset mid-operation discards the buffered loads. Upstream is reset by the same `nRst`.

## Configuration
- `WB_FWD_EN` defined:
  - Adds output `oFwd` (`reg_transport_t`) and `oFwdValid` (1 bit).
  - Both are combinational copies of the value selected this cycle, before the output register. `oFwdValid` is 0 when the selected `addr` is 0.
  - Decode uses them for same-cycle bypass.
- `WB_FWD_EN` undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Package `wb_pkg`:
  - Enum `wb_src_e` with values `WB_SRC_NONE`, `WB_SRC_ALU`, `WB_SRC_FIFO`, `WB_SRC_LD`.
  - Localparam `WB_LD_DEPTH_DEFAULT = 2`.
- `reg_transport_t` is reused from `reg_transport`.
- Sub-module `wb_load_fifo`:
  - Parameterised depth, carrying `reg_transport_t`.
  - Ports: push, pop, head, full, empty, count.
  - Exports its valid entries for `oLdPend`.
- The arbiter FSM is stateless apart from the FIFO and the output register. `wb_src_e` is the mux select.

## Test plan
- **Direct load.** Reset, then `iLdValid=1`, `iLdRd={5,0xDEADBEEF}` for 1 cycle with the ALU idle.
  - Next cycle: `oWriteEn=1`, `oRd={5,0xDEADBEEF}`, `oLdPend=0`.
- **Collision.** Same cycle: ALU `{3,0x11}`, load `{7,0x22}`.
  - Cycle +1: write `{3,0x11}`, `oLdPend[7]=1`.
  - Cycle +2: write `{7,0x22}`, `oLdPend=0`.
- **Full FIFO.** ALU valid every cycle while 3 loads arrive (x8, x9, x10).
  - FIFO fills with x8 and x9. `oLdReady` drops and x10 is held upstream.
  - Next cycle: `oAluStall=1` and x8 is written.
  - Cycle after: the ALU result is written and x10 is accepted.
- **x0 writes.** ALU `{0,0xFFFF}`.
  - `oWriteEn` stays 0 and the value is consumed.
  - A load to x0 never sets `oLdPend[0]`.
- **Reset mid-operation.** Fill the FIFO with 2 entries, then pulse `nRst` low.
  - Immediately: `oWriteEn=0`, `oLdPend=0`, `oLdReady=1`.
  - After release: no stale writes.
- **Forwarding (`WB_FWD_EN`).** ALU `{4,0x1234}`.
  - Same cycle: `oFwdValid=1`, `oFwd={4,0x1234}`.
  - Next cycle: `oRd` matches.
